// File: rtl/pickup_pkg.sv
// Shared constants and state/phase encodings for the pickup stack.
// The separator sub-phase is only reachable when PICKUP_SEPARATOR_EN is defined.
package pickup_pkg;

    localparam int unsigned CH_UPPER_LO = 65;
    localparam int unsigned CH_UPPER_HI = 90;
    localparam int unsigned CH_LOWER_LO = 97;
    localparam int unsigned CH_LOWER_HI = 122;
    localparam int unsigned CH_SEP      = 45;

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DONE} state_e;
    typedef enum logic [1:0] {PASS, THING, SEP} phase_e;

endpackage

// File: rtl/char_stack.sv
// LIFO of DEPTH characters; pushes to a full stack and pops from an empty one are ignored.
// Contents are not reset: the count alone defines what is valid.
module char_stack #(
    parameter int DATA_LEN = 8,
    parameter int DEPTH    = 16,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA_LEN-1:0] din,
    output logic [DATA_LEN-1:0] top,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty
);

    logic [DATA_LEN-1:0] mem_q [DEPTH];
    logic [CW-1:0]       count_q, count_d;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign top   = empty ? '0 : mem_q[AW'(count_q - 1'b1)];

    always_comb begin
        count_d = count_q;
        if (push && !full)
            count_d = count_q + 1'b1;
        else if (pop && !empty)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem_q[AW'(count_q)] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

endmodule

// File: rtl/pickup_stack.sv
// Sorts upstream letters into passenger/thing stacks and emits them LIFO, passenger then thing.
// Define PICKUP_SEPARATOR_EN to insert a '-' cycle after every completed pair.
module pickup_stack
    import pickup_pkg::*;
#(
    parameter int DATA_LEN = 8,
    parameter int DEPTH    = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATA_LEN-1:0] in_data,
    input  logic                in_done,
    output logic                out_valid,
    output logic [DATA_LEN-1:0] out_data,
    output logic                done,
    output logic                overflow
);

    localparam logic [DATA_LEN-1:0] UP_LO = DATA_LEN'(CH_UPPER_LO);
    localparam logic [DATA_LEN-1:0] UP_HI = DATA_LEN'(CH_UPPER_HI);
    localparam logic [DATA_LEN-1:0] LO_LO = DATA_LEN'(CH_LOWER_LO);
    localparam logic [DATA_LEN-1:0] LO_HI = DATA_LEN'(CH_LOWER_HI);

    state_e state_q, state_d;
    phase_e phase_q, phase_d;
    logic   overflow_q, overflow_d;

    logic                p_push, p_pop, p_full, p_empty;
    logic                t_push, t_pop, t_full, t_empty;
    logic [DATA_LEN-1:0] p_top, t_top;
    logic [CW-1:0]       p_count, t_count;
    logic                cap, is_upper, is_lower, use_pass, last;

    char_stack #(.DATA_LEN(DATA_LEN), .DEPTH(DEPTH)) u_pass (
        .clk(clk), .rst(rst), .push(p_push), .pop(p_pop), .din(in_data),
        .top(p_top), .count(p_count), .full(p_full), .empty(p_empty)
    );

    char_stack #(.DATA_LEN(DATA_LEN), .DEPTH(DEPTH)) u_thing (
        .clk(clk), .rst(rst), .push(t_push), .pop(t_pop), .din(in_data),
        .top(t_top), .count(t_count), .full(t_full), .empty(t_empty)
    );

    assign is_upper = (in_data >= UP_LO) && (in_data <= UP_HI);
    assign is_lower = (in_data >= LO_LO) && (in_data <= LO_HI);
    assign cap      = in_valid && ((state_q == IDLE) || (state_q == COLLECT));
    assign p_push   = cap && is_upper && !p_full;
    assign t_push   = cap && is_lower && !t_full;

    // Fall back to the other stack when the phase's stack has run dry.
    assign use_pass = (phase_q == PASS) ? !p_empty : t_empty;
    assign last     = (p_count == CW'(1) && t_empty) || (t_count == CW'(1) && p_empty);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        overflow_d = overflow_q | (cap && ((is_upper && p_full) || (is_lower && t_full)));
        p_pop      = 1'b0;
        t_pop      = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid)     state_d = COLLECT;
                else if (in_done) state_d = DONE;
            end
            COLLECT: begin
                if (in_done)
                    state_d = (p_empty && t_empty && !p_push && !t_push) ? DONE : EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
`ifdef PICKUP_SEPARATOR_EN
                if (phase_q == SEP) begin
                    out_data = DATA_LEN'(CH_SEP);
                    phase_d  = PASS;
                    if (p_empty && t_empty) state_d = DONE;
                end else begin
`else
                begin
`endif
                    out_data = use_pass ? p_top : t_top;
                    p_pop    = use_pass;
                    t_pop    = !use_pass;
                    if (phase_q == PASS && use_pass)
                        phase_d = THING;
                    else if (phase_q == THING && !use_pass)
`ifdef PICKUP_SEPARATOR_EN
                        phase_d = SEP;
`else
                        phase_d = PASS;
`endif
                    if (last && phase_d != SEP) state_d = DONE;
                end
            end
            DONE: done = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign overflow = overflow_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            phase_q    <= PASS;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_pickup_stack.sv
// Directed bench for pickup_stack; expected pickup orders are hand-derived strings.
module tb_pickup_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_done = 1'b0;
    logic       out_valid, done, overflow;
    logic [7:0] out_data;

    int checks   = 0;
    int failures = 0;

    pickup_stack #(.DATA_LEN(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_done(in_done),
        .out_valid(out_valid), .out_data(out_data), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input byte c);
        in_valid = 1'b1;
        in_data  = c;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push(s[i]);
    endtask

    task automatic finish_in();
        in_done = 1'b1;
        @(negedge clk);
        in_done = 1'b0;
    endtask

    task automatic emit(input string tag, input string exp);
        for (int i = 0; i < exp.len(); i++) begin
            chk($sformatf("%s valid[%0d]", tag, i), {31'b0, out_valid}, 1);
            chk($sformatf("%s data[%0d]", tag, i), {24'b0, out_data}, {24'b0, exp[i]});
            @(negedge clk);
        end
        chk({tag, " done"}, {31'b0, done}, 1);
        chk({tag, " valid_off"}, {31'b0, out_valid}, 0);
        chk({tag, " data_zero"}, {24'b0, out_data}, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, " rst valid"}, {31'b0, out_valid}, 0);
        chk({tag, " rst data"}, {24'b0, out_data}, 0);
        chk({tag, " rst done"}, {31'b0, done}, 0);
        chk({tag, " rst overflow"}, {31'b0, overflow}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

`ifdef PICKUP_SEPARATOR_EN
    localparam string EXP1 = "Bb-Aa-";
    localparam string EXP2 = "Ca-BA";
    localparam string EXP6 = "Zz-";
`else
    localparam string EXP1 = "BbAa";
    localparam string EXP2 = "CaBA";
    localparam string EXP6 = "Zz";
`endif

    initial begin
        do_reset("init");

        // Two full pairs
        push_str("AaBb");
        finish_in();
        emit("pairs", EXP1);
        chk("pairs overflow", {31'b0, overflow}, 0);
        do_reset("t1");

        // Unpaired passenger tail
        push_str("ABCa");
        finish_in();
        emit("tail", EXP2);
        chk("tail overflow", {31'b0, overflow}, 0);
        do_reset("t2");

        // Non-letters dropped
        push_str("1$x ");
        finish_in();
        emit("filter", "x");
        do_reset("t3");

        // Passenger stack overflow
        push_str("ABCDEFGHIJKLMNOP");
        chk("ovf before Q", {31'b0, overflow}, 0);
        push("Q");
        chk("ovf after Q", {31'b0, overflow}, 1);
        finish_in();
        emit("full", "PONMLKJIHGFEDCBA");
        chk("full overflow sticky", {31'b0, overflow}, 1);
        do_reset("t4");

        // Done straight from IDLE
        in_done = 1'b1;
        #1;
        chk("idle done pre", {31'b0, done}, 0);
        chk("idle valid pre", {31'b0, out_valid}, 0);
        @(negedge clk);
        in_done = 1'b0;
        chk("idle done", {31'b0, done}, 1);
        chk("idle valid", {31'b0, out_valid}, 0);
        push("A");
        chk("idle ignore push", {31'b0, out_valid}, 0);
        do_reset("t5");

        // Reset during second emit cycle, then a fresh run
        push_str("AaBb");
        finish_in();
        chk("mid first", {24'b0, out_data}, 8'h42);
        @(negedge clk);
        chk("mid second", {24'b0, out_data}, 8'h62);
        #2;
        do_reset("mid");
        push_str("Zz");
        finish_in();
        emit("fresh", EXP6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
